// File: rtl/pulse_sequencer.sv
// ---------------------------------------------------------------------------
// pulse_sequencer
//
// Shot scheduler for the transducer pulse generator. Holds an 8-entry table
// of per-shot pulse configurations and loops over entries 0..i_last_step.
// For each entry it presents the configuration, then issues a sync pulse of
// SYNC_LEN cycles, and repeats at a programmable shot period. This lets one
// pulse generator be time-shared across transmit/receive channel pairs.
//
// Ports
//   rst_n          async active-low reset
//   hi_clk         clock
//   i_enable       run request (level); sampled in IDLE and at the end of a shot
//   i_period       shot period in cycles, clamped below at MIN_PERIOD
//   i_last_step    last table index of the loop, sampled at the end of a shot
//   i_cfg_we       table write strobe (accepted in any state)
//   i_cfg_addr     table entry index for writes
//   i_cfg_data     entry payload: [7:0] width, [15:8] pause, [18:16] count,
//                  [21:19] tx_mask, [24:22] rx_mask; [31:25] ignored
//   o_sync         sync to the pulse generator, high SYNC_LEN cycles per shot
//   o_rx_mask, o_tx_mask, o_pulse_count, o_pulse_width, o_pulse_pause
//                  configuration of the current shot, updated only on LOAD
//   o_step         index of the current entry, updated on LOAD
//   o_frame_start  one-cycle strobe during the LOAD of entry 0
//   o_busy         high from LOAD until the shot period ends
//
// Shot timeline (cnt is the shot counter):
//   LOAD  cnt=0            config/step/busy/frame_start become visible
//   SYNC  cnt=1..SYNC_LEN  o_sync high
//   WAIT  cnt=SYNC_LEN+1..P-1, then next LOAD (or IDLE if disabled)
// so LOAD-to-LOAD is exactly P cycles.
// ---------------------------------------------------------------------------
module pulse_sequencer #(
  parameter int SYNC_LEN   = 4,
  parameter int MIN_PERIOD = SYNC_LEN + 2
) (
  input  logic        rst_n,
  input  logic        hi_clk,
  input  logic        i_enable,
  input  logic [15:0] i_period,
  input  logic [2:0]  i_last_step,
  input  logic        i_cfg_we,
  input  logic [2:0]  i_cfg_addr,
  input  logic [31:0] i_cfg_data,
  output logic        o_sync,
  output logic [2:0]  o_rx_mask,
  output logic [2:0]  o_tx_mask,
  output logic [2:0]  o_pulse_count,
  output logic [7:0]  o_pulse_width,
  output logic [7:0]  o_pulse_pause,
  output logic [2:0]  o_step,
  output logic        o_frame_start,
  output logic        o_busy
);

  localparam logic [15:0] MIN_P    = 16'(MIN_PERIOD);
  localparam logic [15:0] SYNC_END = 16'(SYNC_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SYNC = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] period_q;
  logic [2:0]  step;
  logic [24:0] cfg_q;
  logic [24:0] cfg_table [8];

  logic [15:0] eff_period;
  logic [2:0]  step_next;
  logic        shot_end;

  // Period clamp keeps at least one WAIT cycle after the sync window.
  assign eff_period = (i_period < MIN_P) ? MIN_P : i_period;

  // A lowered i_last_step below the current step wraps the loop to 0.
  assign step_next  = (step >= i_last_step) ? 3'd0 : step + 3'd1;

  assign shot_end   = (cnt == period_q - 16'd1);

  // -------------------------------------------------------------------------
  // Configuration table. Writes land at the clock edge in any state; a write
  // that coincides with the edge copying an entry into cfg_q is seen only on
  // the following visit, because both use non-blocking updates.
  // -------------------------------------------------------------------------
  always_ff @(posedge hi_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        cfg_table[i] <= '0;
      end
    end else if (i_cfg_we) begin
      cfg_table[i_cfg_addr] <= i_cfg_data[24:0];
    end
  end

  // -------------------------------------------------------------------------
  // Sequencer FSM with registered outputs. Config, step, busy and
  // frame_start are loaded on the edge that enters LOAD so they are valid
  // throughout the LOAD cycle; the period is latched on the edge leaving
  // LOAD and held for the rest of the shot.
  // -------------------------------------------------------------------------
  always_ff @(posedge hi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      period_q      <= '0;
      step          <= '0;
      cfg_q         <= '0;
      o_sync        <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= 1'b0;
      case (state)
        IDLE: begin
          cnt    <= '0;
          o_sync <= 1'b0;
          if (i_enable) begin
            state         <= LOAD;
            step          <= 3'd0;
            cfg_q         <= cfg_table[0];
            o_busy        <= 1'b1;
            o_frame_start <= 1'b1;
          end
        end

        LOAD: begin
          period_q <= eff_period;
          cnt      <= 16'd1;
          o_sync   <= 1'b1;
          state    <= SYNC;
        end

        SYNC: begin
          cnt <= cnt + 16'd1;
          if (cnt == SYNC_END) begin
            o_sync <= 1'b0;
            state  <= WAIT;
          end
        end

        WAIT: begin
          if (shot_end) begin
            cnt <= '0;
            if (!i_enable) begin
              state  <= IDLE;
              step   <= 3'd0;
              o_busy <= 1'b0;
            end else begin
              state         <= LOAD;
              step          <= step_next;
              cfg_q         <= cfg_table[step_next];
              o_frame_start <= (step_next == 3'd0);
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= '0;
          o_sync <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_step        = step;
  assign o_pulse_width = cfg_q[7:0];
  assign o_pulse_pause = cfg_q[15:8];
  assign o_pulse_count = cfg_q[18:16];
  assign o_tx_mask     = cfg_q[21:19];
  assign o_rx_mask     = cfg_q[24:22];

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Shot scheduler for the transducer pulse generator. It holds an 8-entry table of per-shot pulse configurations and steps through entries 0..i_last_step in a loop. For each entry it presents the configuration to the pulse generator, then issues a sync pulse. It repeats this at a programmable shot period, so one pulse generator is time-shared across transmit/receive channel pairs. It sits between the host register interface and the pulse generator.

## Interface
Parameters:
- SYNC_LEN, 4, cycles o_sync is held high per shot; must be ≥2 because the pulse generator edge-detects sync with two hi_clk flops.
- MIN_PERIOD, SYNC_LEN+2, lower clamp on the shot period.

Ports:
- rst_n  in  1  reset, asynchronous, active-low.
- hi_clk  in  1  clock.
- i_enable  in  1  run request, level-sensitive.
- i_period  in  16  shot period in hi_clk cycles; the effective period P = max(i_period, MIN_PERIOD).
- i_last_step  in  3  index of the last table entry in the loop.
- i_cfg_we  in  1  table write strobe.
- i_cfg_addr  in  3  table entry index.
- i_cfg_data  in  32  entry payload: [7:0] width, [15:8] pause, [18:16] pulse_count, [21:19] tx_mask, [24:22] rx_mask; bits [31:25] are ignored.
- o_sync  out  1  sync to the pulse generator.
- o_rx_mask, o_tx_mask, o_pulse_count  out  3 each  configuration for the current shot.
- o_pulse_width, o_pulse_pause  out  8 each  configuration for the current shot.
- o_step  out  3  index of the current entry.
- o_frame_start  out  1  one-cycle strobe marking the LOAD of entry 0.
- o_busy  out  1  high from LOAD until the shot period ends.

## Operation
- Table: 8 × 25-bit registers, cleared to 0 on reset.
  - A write with i_cfg_we=1 updates entry i_cfg_addr at the clock edge, in any state.
- State machine with states IDLE, LOAD, SYNC, WAIT.
- Shot counter cnt, 16 bit.
  - cnt=0 in the LOAD cycle and increments by 1 every cycle of the shot.
- IDLE:
  - o_sync=0, o_busy=0, step=0, cnt=0.
  - When i_enable=1, move to LOAD.
- LOAD (1 cycle):
  - Copy table[step] into all config outputs.
  - Latch P.
  - o_busy=1; o_frame_start=1 if step==0.
  - Move to SYNC.
- SYNC:
  - o_sync=1 for cnt=1..SYNC_LEN.
  - After the cycle where cnt==SYNC_LEN, move to WAIT.
- WAIT:
  - o_sync=0; cnt keeps counting.
  - In the cycle where cnt==P-1, advance as follows:
    - If i_enable=0: move to IDLE.
    - Otherwise, move to LOAD with step ← (step ≥ i_last_step) ? 0 : step+1.
- Config outputs change only in LOAD. They hold their values through IDLE and are stable for the entire sync and burst window.
- o_step equals step; it is registered and updates at the LOAD edge.

## Timing
- Reset: async to IDLE. All outputs are 0, table is 0, cnt=0, step=0.
- Start latency: i_enable rising while in IDLE → LOAD on the next edge. Config outputs are valid and o_sync rises one cycle after LOAD.
- Shot period: LOAD to the next LOAD is exactly P cycles.
- The latched P and the config outputs are unaffected by i_period or table writes during a shot.
- Write to an entry in the same cycle as LOAD reads that entry: LOAD takes the old value; the new value is used on the next visit.
- i_last_step is sampled only at the end of WAIT.
  - If it is lowered below the current step, the sequence wraps to 0.
- Disable mid-shot: the current shot completes its full P cycles with o_sync unchanged, then the block enters IDLE.
- Re-enable in IDLE restarts the sequence at step 0.
- i_period < MIN_PERIOD, including 0, uses MIN_PERIOD.
- Reset asserted mid-SYNC drops o_sync immediately (asynchronous).
- The burst must fit within P. Software ensures P > SYNC_LEN + 2 + pulse_count × 2 × (width+pause+2); the block does not check this.

## Test plan
- Write entries 0..2 with distinct configs; set last_step=2, P=100, enable → LOAD at t0, t0+100 and t0+200 present steps 0,1,2; the 4th shot is step 0 with o_frame_start=1.
- Measure o_sync with SYNC_LEN=4 → high for exactly 4 cycles, starting 1 cycle after LOAD; config outputs are stable from LOAD through the next LOAD.
- Set P=3 → shot period is MIN_PERIOD=6 cycles; set P=0 → also 6.
- Drop i_enable 10 cycles into a P=50 shot → o_busy stays high until cycle 49, then IDLE with o_sync=0.
- Re-enable → step 0 is reloaded.
- Write entry 1 during the LOAD of entry 1 → that shot uses the old data and the next loop uses the new data.
- Change i_period from 100 to 40 mid-shot → the current shot still lasts 100, the next lasts 40.
- Assert rst_n low during SYNC of step 2 → all outputs are 0 asynchronously and the table is cleared.
- Release reset with enable=1 → restart at step 0 with zero config.
